// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access path of the single-cycle core.
//   - dmem_state_t : access sequencer states (IDLE/REQ/RESP/ERR)
//   - OPC_LOAD / OPC_STORE : RV32I major opcodes that produce MemRead/MemWrite
//   - DATA_W_DEF / ADDR_W_DEF : default datapath widths
//   - word_aligned() : true when a byte address is 32-bit word aligned
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } dmem_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    function automatic logic word_aligned(input logic [1:0] i_lsb);
        return (i_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// 16-bit counter with synchronous clear and enable.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear to zero (wins over i_en)
//   i_en       : count up by one
//   o_count    : current count
//   o_expired  : count has reached LIMIT-1
// With SAT=1 the counter stops at LIMIT-1 instead of rolling over, which is
// how the stall-cycle statistic saturates at 16'hFFFF (LIMIT=65536).
module dmem_timeout_cnt #(
    parameter int unsigned LIMIT = 255,
    parameter bit          SAT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [15:0] o_count,
    output logic        o_expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] r_count;
    logic        w_at_last;

    assign w_at_last = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= 16'd0;
        end else if (i_en && !(SAT && w_at_last)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count   = r_count;
    assign o_expired = w_at_last;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the single-cycle RISC-V core.
// Turns a decoded MemRead/MemWrite into a req/ack transaction on a multi-cycle
// memory slave, holding the PC (pc_stall) until the access retires.
//   Core side  : mem_read, mem_write, addr, wdata -> pc_stall, rdata,
//                rdata_valid, wb_kill, misalign_err, timeout_err
//   Memory side: dmem_req, dmem_we, dmem_addr, dmem_wdata <- dmem_ack, dmem_rdata
//   Status     : stall_cycles (saturating), dbg_state (FSM state)
// Handshake: dmem_req is held high with stable we/addr/wdata from the first
// REQ cycle until the cycle in which dmem_ack (a one-cycle pulse) is seen, or
// until the timeout aborts the access; dmem_rdata is only sampled with ack.
module dmem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter int          DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              pc_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wb_kill,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [15:0]       stall_cycles,
    output dmem_state_t       dbg_state
);

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_mis;      // ERR cause: 1 = misaligned, 0 = timeout
    logic [DATA_W-1:0] r_rdata;

    logic              w_acc;
    logic              w_aligned;
    logic              w_to_expired;
    logic [15:0]       w_to_count;
    logic              w_stall_sat;
    logic              w_unused;

    assign w_acc     = mem_read | mem_write;
    assign w_aligned = word_aligned(addr[1:0]);

    // Timeout counter is held at zero outside REQ, so every access starts fresh.
    dmem_timeout_cnt #(.LIMIT(TIMEOUT), .SAT(1'b0)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state != S_REQ),
        .i_en      ((r_state == S_REQ) && !dmem_ack),
        .o_count   (w_to_count),
        .o_expired (w_to_expired)
    );

    dmem_timeout_cnt #(.LIMIT(65536), .SAT(1'b1)) u_stall_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (1'b0),
        .i_en      (pc_stall),
        .o_count   (stall_cycles),
        .o_expired (w_stall_sat)
    );

    assign w_unused = ^{w_to_count, w_stall_sat};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_acc) begin
                r_mis <= !w_aligned;
                if (w_aligned) begin
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_we    <= mem_write;  // write wins when both are decoded
                end
            end
            if (r_state == S_REQ && dmem_ack && !r_we) begin
                r_rdata <= dmem_rdata;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        pc_stall     = 1'b0;
        rdata_valid  = 1'b0;
        wb_kill      = 1'b0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    pc_stall = 1'b1;
                    w_next   = w_aligned ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                pc_stall   = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                // An ack arriving in the abort cycle still completes the access.
                if (dmem_ack)          w_next = S_RESP;
                else if (w_to_expired) w_next = S_ERR;
            end
            S_RESP: begin
                rdata_valid = !r_we;
                w_next      = S_IDLE;
            end
            S_ERR: begin
                wb_kill      = 1'b1;
                misalign_err = r_mis;
                timeout_err  = !r_mis;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign rdata     = r_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  // DUT a: default TIMEOUT=255
  logic        a_pc_stall, a_rdata_valid, a_wb_kill, a_mis, a_to;
  logic        a_req, a_we;
  logic [31:0] a_rdata, a_daddr, a_dwdata;
  logic [15:0] a_stall_cycles;
  dmem_state_t a_state;

  // DUT b: TIMEOUT=4
  logic        b_pc_stall, b_rdata_valid, b_wb_kill, b_mis, b_to;
  logic        b_req, b_we;
  logic [31:0] b_rdata, b_daddr, b_dwdata;
  logic [15:0] b_stall_cycles;
  dmem_state_t b_state;

  int n_cmp = 0;
  int n_err = 0;

  dmem_access_ctrl u_dut_a (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .pc_stall(a_pc_stall), .rdata(a_rdata),
    .rdata_valid(a_rdata_valid), .wb_kill(a_wb_kill), .misalign_err(a_mis),
    .timeout_err(a_to), .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_daddr),
    .dmem_wdata(a_dwdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_cycles(a_stall_cycles), .dbg_state(a_state)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .pc_stall(b_pc_stall), .rdata(b_rdata),
    .rdata_valid(b_rdata_valid), .wb_kill(b_wb_kill), .misalign_err(b_mis),
    .timeout_err(b_to), .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_daddr),
    .dmem_wdata(b_dwdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_cycles(b_stall_cycles), .dbg_state(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs changed afterwards, outputs checked after #1 settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_a_state(input string tag, input dmem_state_t exp);
    check(tag, 32'(a_state), 32'(exp));
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    check_a_state("rst_state", S_IDLE);
    check("rst_pc_stall", 32'(a_pc_stall), 32'd0);
    check("rst_req", 32'(a_req), 32'd0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_stall_cycles", 32'(a_stall_cycles), 32'd0);
    check("rst_daddr", a_daddr, 32'h0);

    // ---------------- aligned load, ack in first REQ cycle
    mem_read = 1'b1; addr = 32'h100;
    #1;
    check("ld_idle_stall", 32'(a_pc_stall), 32'd1);
    check("ld_idle_req", 32'(a_req), 32'd0);
    tick();
    check_a_state("ld_req_state", S_REQ);
    check("ld_req", 32'(a_req), 32'd1);
    check("ld_req_we", 32'(a_we), 32'd0);
    check("ld_req_addr", a_daddr, 32'h100);
    check("ld_req_stall", 32'(a_pc_stall), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0; mem_read = 1'b0;
    #1;
    check_a_state("ld_resp_state", S_RESP);
    check("ld_resp_stall", 32'(a_pc_stall), 32'd0);
    check("ld_resp_valid", 32'(a_rdata_valid), 32'd1);
    check("ld_resp_rdata", a_rdata, 32'hDEADBEEF);
    check("ld_stall_cycles", 32'(a_stall_cycles), 32'd2);
    tick();
    check_a_state("ld_back_idle", S_IDLE);
    check("ld_idle_valid", 32'(a_rdata_valid), 32'd0);
    check("ld_rdata_hold", a_rdata, 32'hDEADBEEF);

    // ---------------- store with 4 wait cycles
    mem_write = 1'b1; addr = 32'h204; wdata = 32'h12345678;
    #1;
    check("st_idle_stall", 32'(a_pc_stall), 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("st_req", 32'(a_req), 32'd1);
      check("st_we", 32'(a_we), 32'd1);
      check("st_addr", a_daddr, 32'h204);
      check("st_wdata", a_dwdata, 32'h12345678);
      check("st_stall", 32'(a_pc_stall), 32'd1);
      if (k == 4) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF0000;  // must not be captured on a write
      end
      tick();
    end
    dmem_ack = 1'b0; dmem_rdata = '0; mem_write = 1'b0;
    #1;
    check_a_state("st_resp_state", S_RESP);
    check("st_resp_valid", 32'(a_rdata_valid), 32'd0);
    check("st_rdata_unchanged", a_rdata, 32'hDEADBEEF);
    check("st_resp_stall", 32'(a_pc_stall), 32'd0);
    check("st_stall_cycles", 32'(a_stall_cycles), 32'd8);
    tick();
    check_a_state("st_back_idle", S_IDLE);

    // ---------------- misaligned load
    mem_read = 1'b1; addr = 32'h103;
    #1;
    check("mis_idle_stall", 32'(a_pc_stall), 32'd1);
    check("mis_idle_req", 32'(a_req), 32'd0);
    tick();
    mem_read = 1'b0;
    #1;
    check_a_state("mis_err_state", S_ERR);
    check("mis_err_flag", 32'(a_mis), 32'd1);
    check("mis_to_flag", 32'(a_to), 32'd0);
    check("mis_wb_kill", 32'(a_wb_kill), 32'd1);
    check("mis_err_stall", 32'(a_pc_stall), 32'd0);
    check("mis_err_req", 32'(a_req), 32'd0);
    tick();
    check_a_state("mis_back_idle", S_IDLE);
    check("mis_flag_gone", 32'(a_mis), 32'd0);
    check("mis_stall_cycles", 32'(a_stall_cycles), 32'd9);

    // ---------------- timeout (DUT b, TIMEOUT=4)
    do_reset();
    mem_read = 1'b1; addr = 32'h40;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("to_req_state", 32'(b_state), 32'(S_REQ));
      check("to_req", 32'(b_req), 32'd1);
      tick();
    end
    mem_read = 1'b0;
    #1;
    check("to_err_state", 32'(b_state), 32'(S_ERR));
    check("to_err_flag", 32'(b_to), 32'd1);
    check("to_mis_flag", 32'(b_mis), 32'd0);
    check("to_err_req", 32'(b_req), 32'd0);
    check("to_wb_kill", 32'(b_wb_kill), 32'd1);
    check("to_err_stall", 32'(b_pc_stall), 32'd0);
    tick();
    check("to_back_idle", 32'(b_state), 32'(S_IDLE));
    check("to_flag_gone", 32'(b_to), 32'd0);
    // same again, ack in the abort cycle
    mem_read = 1'b1; addr = 32'h44;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("to2_req", 32'(b_req), 32'd1);
      if (k == 3) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
      end
      tick();
    end
    dmem_ack = 1'b0; dmem_rdata = '0; mem_read = 1'b0;
    #1;
    check("to2_resp_state", 32'(b_state), 32'(S_RESP));
    check("to2_no_to_err", 32'(b_to), 32'd0);
    check("to2_no_kill", 32'(b_wb_kill), 32'd0);
    check("to2_valid", 32'(b_rdata_valid), 32'd1);
    check("to2_rdata", b_rdata, 32'h0BADF00D);

    // ---------------- reset during REQ
    do_reset();
    mem_read = 1'b1; addr = 32'h10;
    tick();
    tick();
    check_a_state("rr_in_req", S_REQ);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_read = 1'b0;
    #1;
    check_a_state("rr_state", S_IDLE);
    check("rr_req", 32'(a_req), 32'd0);
    check("rr_stall", 32'(a_pc_stall), 32'd0);
    check("rr_stall_cycles", 32'(a_stall_cycles), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    #1;
    check_a_state("rr_spur_state", S_IDLE);
    check("rr_spur_valid", 32'(a_rdata_valid), 32'd0);
    check("rr_spur_rdata", a_rdata, 32'h0);

    // ---------------- read+write together -> write
    mem_read = 1'b1; mem_write = 1'b1; addr = 32'h8; wdata = 32'hCAFE0001;
    tick();
    check("rw_we", 32'(a_we), 32'd1);
    check("rw_addr", a_daddr, 32'h8);
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0;
    // next instruction (load at 0x20) is presented while RESP retires
    mem_write = 1'b0; mem_read = 1'b1; addr = 32'h20;
    #1;
    check_a_state("rw_resp_state", S_RESP);
    check("rw_resp_valid", 32'(a_rdata_valid), 32'd0);
    check("rw_rdata_unchanged", a_rdata, 32'h0);

    // ---------------- back-to-back loads
    tick();
    check_a_state("bb1_idle", S_IDLE);
    check("bb1_idle_stall", 32'(a_pc_stall), 32'd1);
    tick();
    check_a_state("bb1_req", S_REQ);
    check("bb1_addr", a_daddr, 32'h20);
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0; addr = 32'h24;
    #1;
    check("bb1_rdata", a_rdata, 32'hA5A5A5A5);
    check("bb1_valid", 32'(a_rdata_valid), 32'd1);
    tick();
    check_a_state("bb2_idle", S_IDLE);
    tick();
    check_a_state("bb2_req", S_REQ);
    check("bb2_addr", a_daddr, 32'h24);
    dmem_ack = 1'b1; dmem_rdata = 32'h5A5A0F0F;
    tick();
    dmem_ack = 1'b0; dmem_rdata = '0; mem_read = 1'b0;
    #1;
    check("bb2_rdata", a_rdata, 32'h5A5A0F0F);
    check("bb2_valid", 32'(a_rdata_valid), 32'd1);
    check("bb_stall_cycles", 32'(a_stall_cycles), 32'd6);
    tick();
    check_a_state("bb_end_idle", S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
